// File: rtl/wb_grf.sv
// Write-back stage: selects the write-back datum, extracts load data, owns the
// register file (two combinational read ports) and counts retired instructions.
// Optional write-through read bypass: define WB_GRF_BYPASS_EN.
module wb_grf #(
  parameter int unsigned NREG     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        W_valid,
  input  logic [31:0] W_PC,
  input  logic [4:0]  W_A3,
  input  logic [2:0]  W_wsel,
  input  logic [2:0]  W_ldtype,
  input  logic [31:0] W_DR,
  input  logic [31:0] W_AO,
  input  logic [31:0] W_RA,
  input  logic [31:0] W_MD,
  input  logic [31:0] W_CP0,
  input  logic [4:0]  D_A1,
  input  logic [4:0]  D_A2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic [31:0] W_WD,
  output logic        W_we,
  output logic [31:0] retired
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  localparam logic [2:0] WSEL_AO  = 3'd0;
  localparam logic [2:0] WSEL_LD  = 3'd1;
  localparam logic [2:0] WSEL_RA  = 3'd2;
  localparam logic [2:0] WSEL_MD  = 3'd3;
  localparam logic [2:0] WSEL_CP0 = 3'd4;

  localparam logic [2:0] LD_LBU = 3'd1;
  localparam logic [2:0] LD_LB  = 3'd2;
  localparam logic [2:0] LD_LHU = 3'd3;
  localparam logic [2:0] LD_LH  = 3'd4;

  logic [DW-1:0] r_grf [NREG];
  logic [DW-1:0] r_retired;

  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [DW-1:0] w_load;
  logic [DW-1:0] w_wd;
  logic          w_we;
  logic [DW-1:0] w_rd1_arr;
  logic [DW-1:0] w_rd2_arr;

  // Byte/halfword lane selection from the low address bits; AO[0] ignored for halves
  always_comb begin
    w_byte = W_DR[7:0];
    case (W_AO[1:0])
      2'd0: w_byte = W_DR[7:0];
      2'd1: w_byte = W_DR[15:8];
      2'd2: w_byte = W_DR[23:16];
      2'd3: w_byte = W_DR[31:24];
      default: w_byte = W_DR[7:0];
    endcase
    w_half = W_AO[1] ? W_DR[31:16] : W_DR[15:0];
  end

  // Load extension; unknown load types behave as a full word
  always_comb begin
    w_load = W_DR;
    case (W_ldtype)
      LD_LBU:  w_load = {24'd0, w_byte};
      LD_LB:   w_load = {{24{w_byte[7]}}, w_byte};
      LD_LHU:  w_load = {16'd0, w_half};
      LD_LH:   w_load = {{16{w_half[15]}}, w_half};
      default: w_load = W_DR;
    endcase
  end

  always_comb begin
    w_wd = '0;
    case (W_wsel)
      WSEL_AO:  w_wd = W_AO;
      WSEL_LD:  w_wd = w_load;
      WSEL_RA:  w_wd = W_RA;
      WSEL_MD:  w_wd = W_MD;
      WSEL_CP0: w_wd = W_CP0;
      default:  w_wd = '0;
    endcase
  end

  assign w_we = W_valid && (W_A3 != AW'(0)) && (W_wsel <= WSEL_CP0);
  assign W_WD = w_wd;
  assign W_we = w_we;

  // Register file; reset clears every entry and overrides a pending write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) begin
        r_grf[i] <= '0;
      end
    end else if (w_we) begin
      r_grf[W_A3] <= w_wd;
    end
  end

  // Retired-instruction counter; bubbles carry RESET_PC and are skipped
  always_ff @(posedge clk) begin
    if (reset) begin
      r_retired <= '0;
    end else if (W_valid && (W_PC != RESET_PC)) begin
      r_retired <= r_retired + DW'(1);
    end
  end

  assign retired = r_retired;

  assign w_rd1_arr = (D_A1 == AW'(0)) ? '0 : r_grf[D_A1];
  assign w_rd2_arr = (D_A2 == AW'(0)) ? '0 : r_grf[D_A2];

`ifdef WB_GRF_BYPASS_EN
  // Write-through: a same-cycle write is visible on the read ports
  assign RD1 = (w_we && (D_A1 == W_A3)) ? w_wd : w_rd1_arr;
  assign RD2 = (w_we && (D_A2 == W_A3)) ? w_wd : w_rd2_arr;
`else
  assign RD1 = w_rd1_arr;
  assign RD2 = w_rd2_arr;
`endif

endmodule

// File: tb/tb_wb_grf.sv
// Directed testbench for wb_grf: reset, write-back selection, load extraction,
// write blocking, read timing and the retired counter.
module tb_wb_grf;

  logic        clk;
  logic        reset;
  logic        W_valid;
  logic [31:0] W_PC;
  logic [4:0]  W_A3;
  logic [2:0]  W_wsel;
  logic [2:0]  W_ldtype;
  logic [31:0] W_DR;
  logic [31:0] W_AO;
  logic [31:0] W_RA;
  logic [31:0] W_MD;
  logic [31:0] W_CP0;
  logic [4:0]  D_A1;
  logic [4:0]  D_A2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [31:0] W_WD;
  logic        W_we;
  logic [31:0] retired;

  int n_checks = 0;
  int n_errors = 0;

  wb_grf #(.NREG(32), .RESET_PC(32'h0000_3000)) dut (
    .clk      (clk),
    .reset    (reset),
    .W_valid  (W_valid),
    .W_PC     (W_PC),
    .W_A3     (W_A3),
    .W_wsel   (W_wsel),
    .W_ldtype (W_ldtype),
    .W_DR     (W_DR),
    .W_AO     (W_AO),
    .W_RA     (W_RA),
    .W_MD     (W_MD),
    .W_CP0    (W_CP0),
    .D_A1     (D_A1),
    .D_A2     (D_A2),
    .RD1      (RD1),
    .RD2      (RD2),
    .W_WD     (W_WD),
    .W_we     (W_we),
    .retired  (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_load(input string tag, input logic [2:0] ldt, input logic [31:0] ao,
                            input logic [31:0] exp);
    W_wsel   = 3'd1;
    W_ldtype = ldt;
    W_AO     = ao;
    #1;
    check(tag, W_WD, exp);
  endtask

  initial begin
    reset = 1'b1; W_valid = 1'b0; W_PC = 32'h0; W_A3 = 5'd0; W_wsel = 3'd0;
    W_ldtype = 3'd0; W_DR = 32'h0; W_AO = 32'h0; W_RA = 32'h0; W_MD = 32'h0;
    W_CP0 = 32'h0; D_A1 = 5'd0; D_A2 = 5'd0;
    tick();
    tick();
    reset = 1'b0;

    // All registers read zero after reset
    for (int a = 0; a < 32; a++) begin
      D_A1 = 5'(a);
      D_A2 = 5'(31 - a);
      #1;
      check("reset_rd1", RD1, 32'h0);
      check("reset_rd2", RD2, 32'h0);
    end
    check("reset_retired", retired, 32'h0);

    // ALU write to r8, visible next cycle
    W_valid = 1'b1; W_PC = 32'h0000_0100; W_A3 = 5'd8; W_wsel = 3'd0; W_AO = 32'h1234_5678;
    #1;
    check("alu_we", {31'd0, W_we}, 32'd1);
    check("alu_wd", W_WD, 32'h1234_5678);
    tick();
    W_valid = 1'b0; D_A1 = 5'd8;
    #1;
    check("alu_rd1", RD1, 32'h1234_5678);
    check("alu_retired", retired, 32'd1);

    // Load extraction
    W_DR = 32'h80FF_7F01;
    check_load("lb_b3",  3'd2, 32'h3, 32'hFFFF_FF80);
    check_load("lhu_h1", 3'd3, 32'h2, 32'h0000_80FF);
    check_load("lbu_b0", 3'd1, 32'h0, 32'h0000_0001);
    check_load("lbu_b2", 3'd1, 32'h2, 32'h0000_00FF);
    check_load("lb_b1",  3'd2, 32'h1, 32'h0000_007F);
    check_load("lh_a1",  3'd4, 32'h1, 32'h0000_7F01);
    check_load("lh_h1",  3'd4, 32'h2, 32'hFFFF_80FF);
    check_load("lw",     3'd0, 32'h2, 32'h80FF_7F01);
    check_load("ld6_lw", 3'd6, 32'h1, 32'h80FF_7F01);

    // Other write-back sources
    W_RA = 32'h0000_3008; W_MD = 32'hCAFE_0002; W_CP0 = 32'h1000_0403;
    W_wsel = 3'd2; #1; check("sel_ra", W_WD, 32'h0000_3008);
    W_wsel = 3'd3; #1; check("sel_md", W_WD, 32'hCAFE_0002);
    W_wsel = 3'd4; #1; check("sel_cp0", W_WD, 32'h1000_0403);
    W_wsel = 3'd7; #1; check("sel_none", W_WD, 32'h0);

    // Write to r0 is blocked
    W_valid = 1'b1; W_PC = 32'h0000_0104; W_A3 = 5'd0; W_wsel = 3'd0; W_AO = 32'hDEAD_BEEF;
    D_A1 = 5'd0;
    #1;
    check("r0_we", {31'd0, W_we}, 32'd0);
    tick();
    W_valid = 1'b0;
    #1;
    check("r0_rd1", RD1, 32'h0);

    // wsel 6 blocks the write
    W_valid = 1'b1; W_PC = 32'h0000_0108; W_A3 = 5'd5; W_wsel = 3'd6;
    #1;
    check("ws6_we", {31'd0, W_we}, 32'd0);
    check("ws6_wd", W_WD, 32'h0);
    tick();
    W_valid = 1'b0; D_A1 = 5'd5;
    #1;
    check("ws6_rd1", RD1, 32'h0);
    check("ws6_retired", retired, 32'd3);

    // Invalid instruction does not write
    W_wsel = 3'd0; #1;
    check("inval_we", {31'd0, W_we}, 32'd0);

    // Bubble PC writes but is not counted
    W_valid = 1'b1; W_PC = 32'h0000_3000; W_A3 = 5'd6; W_wsel = 3'd0; W_AO = 32'h0000_0077;
    tick();
    W_valid = 1'b0; D_A1 = 5'd6;
    #1;
    check("bubble_rd1", RD1, 32'h0000_0077);
    check("bubble_retired", retired, 32'd3);

    // Same-cycle write/read of r9
    W_valid = 1'b1; W_PC = 32'h0000_0200; W_A3 = 5'd9; W_AO = 32'h1111_2222;
    tick();
    W_AO = 32'hA5A5_0001; W_PC = 32'h0000_0204; D_A1 = 5'd9; D_A2 = 5'd9;
    #1;
`ifdef WB_GRF_BYPASS_EN
    check("same_rd2", RD2, 32'hA5A5_0001);
    check("same_rd1", RD1, 32'hA5A5_0001);
`else
    check("same_rd2", RD2, 32'h1111_2222);
    check("same_rd1", RD1, 32'h1111_2222);
`endif
    tick();
    W_valid = 1'b0;
    #1;
    check("next_rd2", RD2, 32'hA5A5_0001);
    check("next_rd1", RD1, 32'hA5A5_0001);
    check("pre_wrap_retired", retired, 32'd5);

    // Counter wrap from all-ones
    force dut.r_retired = 32'hFFFF_FFFF;
    #1;
    release dut.r_retired;
    #1;
    W_valid = 1'b1; W_PC = 32'h0000_0300; W_wsel = 3'd7;
    tick();
    W_valid = 1'b0;
    #1;
    check("wrap_retired", retired, 32'h0);
    W_valid = 1'b1; W_PC = 32'h0000_0304;
    tick();
    W_valid = 1'b0;
    #1;
    check("after_wrap_retired", retired, 32'd1);

    // Reset beats a pending write
    W_valid = 1'b1; W_PC = 32'h0000_0400; W_A3 = 5'd10; W_wsel = 3'd0; W_AO = 32'hCAFE_BABE;
    reset = 1'b1;
    tick();
    reset = 1'b0; W_valid = 1'b0; D_A1 = 5'd10; D_A2 = 5'd8;
    #1;
    check("rst_wr_rd1", RD1, 32'h0);
    check("rst_clr_rd2", RD2, 32'h0);
    check("rst_wr_retired", retired, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
